// File: rtl/apu_core_package.sv
// -----------------------------------------------------------------------------
// apu_core_package
// Shared constants and types for the APU arbiter slice: default requester count,
// default ID FIFO depth, requester-ID width, and the ID FIFO entry type.
// -----------------------------------------------------------------------------
package apu_core_package;

   localparam int unsigned NUM_REQ_DEFAULT = 4;
   localparam int unsigned DEPTH_DEFAULT   = 4;

   // Width of a requester index for the default requester count.
   localparam int unsigned ID_WIDTH = $clog2(NUM_REQ_DEFAULT);

   // One ID FIFO entry: the index of the requester that issued the operation.
   typedef logic [ID_WIDTH-1:0] id_fifo_entry_t;

endpackage

// File: rtl/riscv_apu_id_fifo.sv
// -----------------------------------------------------------------------------
// riscv_apu_id_fifo
// In-order FIFO of requester IDs for operations issued to the shared APU.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     enqueue an ID (ignored when full)
//   pop_i, data_o      dequeue the head ID (ignored when empty); data_o = head
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module riscv_apu_id_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ID_W  = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [ID_W-1:0]  data_i,
   input  logic             pop_i,
   output logic [ID_W-1:0]  data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/riscv_apu_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_apu_arbiter
// Round-robin arbiter sharing one APU between NUM_REQ cores. Issued operations
// are tracked in an in-order ID FIFO so that results, which the APU returns in
// issue order, are routed back to the requester that issued them.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   slv_req_i/slv_gnt_o           per-requester request / grant (acceptance)
//   slv_data_i                    per-requester operation payload
//   slv_valid_o/slv_result_o      per-requester result valid / shared result
//   apu_master_*                  request/grant/data and result side of the APU
//   outstanding_o, busy_o         in-flight operation count / count non-zero
// -----------------------------------------------------------------------------
module riscv_apu_arbiter
   import apu_core_package::*;
#(
   parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
   parameter int unsigned DEPTH      = DEPTH_DEFAULT,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned ID_W  = $clog2(NUM_REQ),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NUM_REQ-1:0]                 slv_req_i,
   output logic [NUM_REQ-1:0]                 slv_gnt_o,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slv_data_i,
   output logic [NUM_REQ-1:0]                 slv_valid_o,
   output logic [DATA_WIDTH-1:0]              slv_result_o,
   output logic                               apu_master_req_o,
   input  logic                               apu_master_gnt_i,
   output logic [DATA_WIDTH-1:0]              apu_master_data_o,
   input  logic                               apu_master_valid_i,
   input  logic [DATA_WIDTH-1:0]              apu_master_result_i,
   output logic                               apu_master_ready_o,
   output logic [CNT_W-1:0]                   outstanding_o,
   output logic                               busy_o
);

   localparam int unsigned IDX_W = ID_W + 1;

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] winner;
   logic            found;
   logic            accept;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [ID_W-1:0] head_id;

   // Round-robin search starting at rr_ptr_q. The candidate index is kept one
   // bit wider so the wrap-around works for non-power-of-two NUM_REQ.
   always_comb begin : rr_search
      logic [IDX_W-1:0] idx;
      idx    = '0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         idx = {1'b0, rr_ptr_q} + IDX_W'(i);
         if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
         if (!found && slv_req_i[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

   // Full blocks issue regardless of a same-cycle pop, so the request never
   // depends combinationally on apu_master_valid_i.
   assign apu_master_req_o   = (|slv_req_i) & ~fifo_full;
   assign apu_master_data_o  = found ? slv_data_i[winner] : '0;
   assign apu_master_ready_o = 1'b1;
   assign accept             = apu_master_gnt_i & apu_master_req_o;

   assign pop          = apu_master_valid_i & ~fifo_empty;
   assign slv_result_o = apu_master_result_i;
   assign busy_o       = (outstanding_o != '0);

   for (genvar gi = 0; gi < int'(NUM_REQ); gi++) begin : g_slv
      assign slv_gnt_o[gi]   = accept && (winner == ID_W'(gi));
      assign slv_valid_o[gi] = pop && (head_id == ID_W'(gi));
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_ptr_q <= '0;
      else         rr_ptr_q <= rr_ptr_d;
   end

   riscv_apu_id_fifo #(
      .DEPTH (DEPTH),
      .ID_W  (ID_W)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .data_i  (winner),
      .pop_i   (pop),
      .data_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outstanding_o)
   );

   // A result with nothing outstanding is dropped; flag it for debug.
   spurious_return_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(apu_master_valid_i && fifo_empty))
      else $warning("APU result returned with no operation outstanding");

endmodule
